// File: rtl/output_switch_if.sv
// Pin-side bundle of the CPU output switch: both CPU GPIO ports, the select line
// and the pad-facing outputs with status.
interface output_switch_if #(
  parameter int WIDTH = 8
);
  logic             ctr_io;
  logic [WIDTH-1:0] out_from_A;
  logic [WIDTH-1:0] oe_from_A;
  logic [WIDTH-1:0] out_from_B;
  logic [WIDTH-1:0] oe_from_B;
  logic [WIDTH-1:0] output_pin;
  logic [WIDTH-1:0] output_oe;
  logic             active_cpu;
  logic             switch_busy;
  logic [7:0]       switch_count;

  modport master (
    output ctr_io, out_from_A, oe_from_A, out_from_B, oe_from_B,
    input  output_pin, output_oe, active_cpu, switch_busy, switch_count
  );

  modport slave (
    input  ctr_io, out_from_A, oe_from_A, out_from_B, oe_from_B,
    output output_pin, output_oe, active_cpu, switch_busy, switch_count
  );
endinterface

// File: rtl/output_switch.sv
// Break-before-make selector of CPU A or CPU B onto the shared output pads; the
// pads sit at a safe value with enables off for a full guard interval on every change.
module output_switch #(
  parameter int               WIDTH        = 8,
  parameter int               SYNC_STAGES  = 2,
  parameter int               GUARD_CYCLES = 4,
  parameter logic [WIDTH-1:0] SAFE_VALUE   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  output_switch_if.slave   bus
);

  localparam int               CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  localparam logic [1:0] ST_ACTIVE_A = 2'd0;
  localparam logic [1:0] ST_ACTIVE_B = 2'd1;
  localparam logic [1:0] ST_GUARD    = 2'd2;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sel_s;
  logic [1:0]             state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0]       pin_r, pin_s;
  logic [WIDTH-1:0]       oe_r, oe_s;
  logic                   active_r, active_s;
  logic                   busy_r, busy_s;
  logic                   first_r, first_s;
  logic [7:0]             count_r, count_s;

  // Select-line synchroniser; nothing else looks at the raw ctr_io
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.ctr_io};
    end
  end

  assign sel_s = sync_r[SYNC_STAGES-1];

  // Next-state and next-output selection for the switch FSM
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pin_s    = pin_r;
    oe_s     = oe_r;
    active_s = active_r;
    busy_s   = busy_r;
    first_s  = first_r;
    count_s  = count_r;
    case (state_r)
      ST_ACTIVE_A: begin
        if (sel_s) begin
          state_s = ST_GUARD;
          cnt_s   = GUARD_LOAD;
          pin_s   = SAFE_VALUE;
          oe_s    = {WIDTH{1'b0}};
          busy_s  = 1'b1;
        end else begin
          pin_s = bus.out_from_A;
          oe_s  = bus.oe_from_A;
        end
      end
      ST_ACTIVE_B: begin
        if (!sel_s) begin
          state_s = ST_GUARD;
          cnt_s   = GUARD_LOAD;
          pin_s   = SAFE_VALUE;
          oe_s    = {WIDTH{1'b0}};
          busy_s  = 1'b1;
        end else begin
          pin_s = bus.out_from_B;
          oe_s  = bus.oe_from_B;
        end
      end
      ST_GUARD: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          // Destination depends only on sel_s at this edge, never on the entry cause
          state_s  = sel_s ? ST_ACTIVE_B : ST_ACTIVE_A;
          pin_s    = sel_s ? bus.out_from_B : bus.out_from_A;
          oe_s     = sel_s ? bus.oe_from_B : bus.oe_from_A;
          active_s = sel_s;
          busy_s   = 1'b0;
          first_s  = 1'b0;
          if (!first_r && (sel_s != active_r) && (count_r != 8'hFF)) begin
            count_s = count_r + 8'd1;
          end else begin
            count_s = count_r;
          end
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          pin_s = SAFE_VALUE;
          oe_s  = {WIDTH{1'b0}};
        end
      end
      default: begin
        state_s = ST_GUARD;
        cnt_s   = GUARD_LOAD;
        pin_s   = SAFE_VALUE;
        oe_s    = {WIDTH{1'b0}};
        busy_s  = 1'b1;
      end
    endcase
  end

  // State, counters and registered pad outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_GUARD;
      cnt_r    <= GUARD_LOAD;
      pin_r    <= SAFE_VALUE;
      oe_r     <= {WIDTH{1'b0}};
      active_r <= 1'b0;
      busy_r   <= 1'b1;
      first_r  <= 1'b1;
      count_r  <= 8'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pin_r    <= pin_s;
      oe_r     <= oe_s;
      active_r <= active_s;
      busy_r   <= busy_s;
      first_r  <= first_s;
      count_r  <= count_s;
    end
  end

  assign bus.output_pin   = pin_r;
  assign bus.output_oe    = oe_r;
  assign bus.active_cpu   = active_r;
  assign bus.switch_busy  = busy_r;
  assign bus.switch_count = count_r;

endmodule

// File: tb/tb_output_switch.sv
// Scoreboard bench for output_switch: stimulus queues per-edge expectations, a
// negedge monitor pops and compares them against the pads and status outputs.
module tb_output_switch;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_switch_if #(.WIDTH(W)) bus();

  output_switch #(
    .WIDTH(W), .SYNC_STAGES(2), .GUARD_CYCLES(4), .SAFE_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    int         edge_no;
    logic [7:0] pin;
    logic [7:0] oe;
    logic       act;
    logic       busy;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;

  // Bench-side model of the design's visible state
  logic       cur_sel = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] a_d, a_e, b_d, b_e;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic compare(input string tag, input logic [7:0] pin, input logic [7:0] oe,
                         input logic act, input logic busy, input logic [7:0] cnt);
    checks++;
    if ({bus.output_pin, bus.output_oe, bus.active_cpu, bus.switch_busy, bus.switch_count}
        !== {pin, oe, act, busy, cnt}) begin
      errors++;
      $display("FAIL %s @edge %0d: got pin=%h oe=%h act=%b busy=%b cnt=%0d, want pin=%h oe=%h act=%b busy=%b cnt=%0d",
               tag, edge_n, bus.output_pin, bus.output_oe, bus.active_cpu, bus.switch_busy,
               bus.switch_count, pin, oe, act, busy, cnt);
    end
  endtask

  // Scoreboard monitor: checks every expectation due at the edge just passed
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_n) begin
      e = sb_q.pop_front();
      if (e.edge_no < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)", e.tag, e.edge_no, edge_n);
      end else begin
        compare(e.tag, e.pin, e.oe, e.act, e.busy, e.cnt);
      end
    end
  end

  task automatic push(input int edge_no, input logic [7:0] pin, input logic [7:0] oe,
                      input logic act, input logic busy, input logic [7:0] cnt, input string tag);
    exp_t e;
    e.edge_no = edge_no; e.pin = pin; e.oe = oe; e.act = act; e.busy = busy; e.cnt = cnt; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cpus(input logic [7:0] ad, input logic [7:0] ae, input logic [7:0] bd, input logic [7:0] be);
    a_d = ad; a_e = ae; b_d = bd; b_e = be;
    bus.out_from_A = ad; bus.oe_from_A = ae; bus.out_from_B = bd; bus.oe_from_B = be;
  endtask

  // Select change just before edge e+1: old CPU for two edges, safe e+3..e+6, new CPU at e+7
  task automatic expect_switch(input string tag, input logic final_sel);
    int e;
    e = edge_n;
    for (int k = 1; k <= 2; k++)
      push(e + k, cur_sel ? b_d : a_d, cur_sel ? b_e : a_e, cur_sel, 1'b0, exp_cnt, {tag, "_pre"});
    for (int k = 3; k <= 6; k++)
      push(e + k, 8'h00, 8'h00, cur_sel, 1'b1, exp_cnt, {tag, "_guard"});
    if (final_sel != cur_sel && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
    cur_sel = final_sel;
    push(e + 7, final_sel ? b_d : a_d, final_sel ? b_e : a_e, final_sel, 1'b0, exp_cnt, {tag, "_exit"});
  endtask

  // Called with rst_n low: check the async reset state, then release and replay power-up
  task automatic reset_release(input string tag);
    int e;
    #1;
    compare({tag, "_async"}, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00);
    bus.ctr_io = 1'b0;
    set_cpus(8'hA5, 8'hFF, 8'h3C, 8'h0F);
    tick(1);
    rst_n = 1'b1;
    e = edge_n;
    for (int k = 1; k <= 3; k++) push(e + k, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, {tag, "_guard"});
    push(e + 4, 8'hA5, 8'hFF, 1'b0, 1'b0, 8'h00, {tag, "_connA"});
    cur_sel = 1'b0;
    exp_cnt = 8'd0;
    tick(5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bus.ctr_io = 1'b0;
    set_cpus(8'hA5, 8'hFF, 8'h3C, 8'h0F);
    tick(2);
    reset_release("por");

    // One-cycle latency from CPU A data to the pads
    e = edge_n;
    set_cpus(8'h5A, 8'hC3, 8'h3C, 8'h0F);
    push(e + 1, 8'h5A, 8'hC3, 1'b0, 1'b0, 8'h00, "latA");
    tick(2);

    // A -> B, then B -> A
    set_cpus(8'hA5, 8'hFF, 8'h3C, 8'h0F);
    tick(1);
    bus.ctr_io = 1'b1;
    expect_switch("a2b", 1'b1);
    tick(8);
    bus.ctr_io = 1'b0;
    expect_switch("b2a", 1'b0);
    tick(8);

    // One-cycle pulse is captured: full guard, back to A, count unchanged
    bus.ctr_io = 1'b1;
    expect_switch("pulse", 1'b0);
    tick(1);
    bus.ctr_io = 1'b0;
    tick(7);

    // Sub-cycle pulse between edges is never sampled
    e = edge_n;
    bus.ctr_io = 1'b1;
    #2;
    bus.ctr_io = 1'b0;
    for (int k = 1; k <= 8; k++) push(e + k, 8'hA5, 8'hFF, 1'b0, 1'b0, exp_cnt, "glitch");
    tick(9);

    // Toggle 1 -> 0 -> 1 inside the guard: guard not extended, exit to B
    bus.ctr_io = 1'b1;
    expect_switch("midguard", 1'b1);
    tick(3);
    bus.ctr_io = 1'b0;
    tick(1);
    bus.ctr_io = 1'b1;
    tick(4);

    // Saturation of switch_count over 260 alternating switchovers
    for (int i = 0; i < 260; i++) begin
      bus.ctr_io = ~cur_sel;
      expect_switch("sat", ~cur_sel);
      tick(8);
    end
    compare("sat_final", cur_sel ? 8'h3C : 8'hA5, cur_sel ? 8'h0F : 8'hFF, cur_sel, 1'b0, 8'd255);

    // Reset in the middle of a guard
    bus.ctr_io = ~cur_sel;
    tick(4);
    #2;
    rst_n = 1'b0;
    reset_release("rst_guard");

    // Reset while connected to A
    tick(3);
    #3;
    rst_n = 1'b0;
    reset_release("rst_active");

    tick(2);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_switch.md
Name: output_switch

Overview:
- Output-direction counterpart of the board's input router. Selects which CPU (A or B) drives the shared 8-bit output pins under `ctr_io`.
- Switchover is break-before-make:
  - `ctr_io` is synchronised first.
  - Pins are forced to a safe value with enables off for a guard interval.
  - The new CPU is then connected.
- Sits between the two CPU cores' GPIO output ports and the board pad drivers.

Parameters:
- WIDTH, 8, pin bus width.
- SYNC_STAGES, 2, flops in the `ctr_io` synchroniser; must be >= 2.
- GUARD_CYCLES, 4, cycles of safe drive between CPUs; must be >= 1.
- SAFE_VALUE, 0, value driven on `output_pin` while not connected.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ctr_io  input  1  select: 0 = CPU A, 1 = CPU B. Asynchronous to clk.
- out_from_A  input  WIDTH  CPU A output data.
- oe_from_A  input  WIDTH  CPU A per-bit output enable.
- out_from_B  input  WIDTH  CPU B output data.
- oe_from_B  input  WIDTH  CPU B per-bit output enable.
- output_pin  output  WIDTH  registered pad data.
- output_oe  output  WIDTH  registered pad enable; 1 = drive.
- active_cpu  output  1  0 = A connected, 1 = B connected. Valid only when switch_busy = 0.
- switch_busy  output  1  1 during guard interval.
- switch_count  output  8  number of completed switchovers; saturates at 255.

Behaviour:
- Reset (rst_n low, immediate):
  - Synchroniser flops = 0.
  - State = GUARD, guard counter = GUARD_CYCLES-1.
  - output_pin = SAFE_VALUE, output_oe = 0.
  - active_cpu = 0, switch_busy = 1, switch_count = 0.
- Synchroniser: `ctr_io` passes through SYNC_STAGES flops. Its last stage is `sel_s`. No logic uses raw `ctr_io`.
- FSM states: ACTIVE_A, ACTIVE_B, GUARD.
- ACTIVE_A:
  - Each edge: output_pin <= out_from_A, output_oe <= oe_from_A.
  - Latency from CPU data to pin is 1 cycle.
  - If sel_s = 1 at an edge, go to GUARD instead: load counter with GUARD_CYCLES-1, output_pin <= SAFE_VALUE, output_oe <= 0, switch_busy <= 1.
- ACTIVE_B: mirror of ACTIVE_A using the B inputs; leaves on sel_s = 0.
- GUARD:
  - Outputs held safe.
  - Counter decrements each edge.
  - At the edge where counter = 0:
    - Enter ACTIVE_A if sel_s = 0, else ACTIVE_B.
    - Register that CPU's data/oe on the same edge.
    - active_cpu <= sel_s, switch_busy <= 0.
  - switch_count increments (saturating) only if the new active_cpu differs from the previous one. The exit from the post-reset guard never counts.
- Guard always runs to completion.
  - `ctr_io` toggling during GUARD does not restart or extend it.
  - The destination is decided solely by sel_s at the exit edge. A glitch back to the original value therefore returns to the original CPU after a full guard, and switch_count is unchanged.
- Switch timing, SYNC_STAGES = 2, GUARD_CYCLES = 4, `ctr_io` rising just before edge 0:
  - sel_s = 1 after edge 1.
  - GUARD entered at edge 2; safe drive from edge 2 through edge 5.
  - B data on pins from edge 6.
- Post-reset timing: first CPU connection at the GUARD_CYCLES-th edge after rst_n deasserts, selected per sel_s at that edge.
- output_pin and output_oe are never driven from the non-selected CPU, and never hold a mix of both CPUs in any cycle.
- No tristate (`z`) values are generated internally. Pad tristating is controlled by output_oe.

Test Plan:
- Reset release with ctr_io = 0, out_from_A = 8'hA5, oe_from_A = 8'hFF -> output_pin = 0 and output_oe = 0 for edges 1-3; at edge 4 output_pin = A5, output_oe = FF, active_cpu = 0, switch_busy = 0, switch_count = 0.
- In ACTIVE_A, raise ctr_io before edge 0, out_from_B = 8'h3C, oe_from_B = 8'h0F -> switch_busy = 1 and pins 0/oe 0 from edge 2 through 5; edge 6 output_pin = 3C, output_oe = 0F, active_cpu = 1, switch_count = 1.
- ctr_io pulses high for 1 cycle only while in ACTIVE_A -> if captured, a full 4-cycle guard runs, then return to A with switch_count unchanged. A pulse shorter than a clock period produces no pin change except the possible guard.
- ctr_io toggles 1 -> 0 mid-guard, with final sel_s = 1 at the exit edge -> exit to B, guard length exactly 4 cycles.
- 260 alternating switchovers -> switch_count saturates at 255 and does not wrap.
- Assert rst_n low mid-guard and mid-active -> outputs go safe immediately, asynchronously; after release the post-reset sequence repeats identically.
